// File: rtl/board_ram_arbiter_pkg.sv
// board_ram_arbiter_pkg: shared grid geometry, bus widths and read-tag encoding
package board_ram_arbiter_pkg;
  localparam int DEF_GRID_N = 8;
  localparam int DEF_H_OFFSET = 160;
  localparam int DEF_COL_W = 72;
  localparam int DEF_V_OFFSET = 50;
  localparam int DEF_ROW_W = 56;
  localparam int AW = 6;
  localparam int DW = 4;
  localparam int RCW = 3;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_GAME = 2'd2} tag_e;
endpackage

// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: scan position, game request/response and RAM port bundle
interface board_ram_arbiter_if;
  import board_ram_arbiter_pkg::*;
  logic pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic ram_en;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic cell_valid;
  logic [DW-1:0] cell_data;
  logic [RCW-1:0] cell_row;
  logic [RCW-1:0] cell_col;
  modport slave (
    input pix_en, hCount, vCount, req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata,
    output cell_valid, cell_data, cell_row, cell_col
  );
  modport master (
    output pix_en, hCount, vCount, req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_wdata,
    input cell_valid, cell_data, cell_row, cell_col
  );
endinterface

// File: rtl/board_ram_arbiter_grid_cell_decode.sv
// grid_cell_decode: maps scan position to in-grid flag and cell row/col with comparator chains
module grid_cell_decode
  import board_ram_arbiter_pkg::*;
#(
  parameter int GRID_N = DEF_GRID_N,
  parameter int H_OFFSET = DEF_H_OFFSET,
  parameter int COL_W = DEF_COL_W,
  parameter int V_OFFSET = DEF_V_OFFSET,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic [9:0] i_hcount,
  input  logic [9:0] i_vcount,
  output logic o_in_grid,
  output logic [RCW-1:0] o_row,
  output logic [RCW-1:0] o_col
);
  // each boundary passed bumps the index, so no divider is needed
  always_comb begin
    o_in_grid = 32'(i_hcount) > H_OFFSET && 32'(i_hcount) < H_OFFSET + GRID_N*COL_W &&
                32'(i_vcount) > V_OFFSET && 32'(i_vcount) < V_OFFSET + GRID_N*ROW_W;
    o_col = '0;
    o_row = '0;
    for (int k = 1; k < GRID_N; k++) begin
      if (32'(i_hcount) > H_OFFSET + k*COL_W) o_col = RCW'(k);
      if (32'(i_vcount) > V_OFFSET + k*ROW_W) o_row = RCW'(k);
    end
  end
endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: single-port board RAM shared by display scan (priority) and game requests
module board_ram_arbiter
  import board_ram_arbiter_pkg::*;
#(
  parameter int GRID_N = DEF_GRID_N,
  parameter int H_OFFSET = DEF_H_OFFSET,
  parameter int COL_W = DEF_COL_W,
  parameter int V_OFFSET = DEF_V_OFFSET,
  parameter int ROW_W = DEF_ROW_W
) (
  input logic clk,
  input logic reset,
  board_ram_arbiter_if.slave bus
);
  logic w_in_grid;
  logic [RCW-1:0] w_row;
  logic [RCW-1:0] w_col;
  logic w_slot;
  logic w_ready;
  logic w_accept;
  logic r_ram_en;
  logic r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  tag_e r_tag0;
  tag_e r_tag1;
  logic [AW-1:0] r_pos1;
  logic r_cell_valid;
  logic [DW-1:0] r_cell_data;
  logic [RCW-1:0] r_cell_row;
  logic [RCW-1:0] r_cell_col;
  logic r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

  grid_cell_decode #(
    .GRID_N(GRID_N), .H_OFFSET(H_OFFSET), .COL_W(COL_W), .V_OFFSET(V_OFFSET), .ROW_W(ROW_W)
  ) u_decode (
    .i_hcount(bus.hCount), .i_vcount(bus.vCount),
    .o_in_grid(w_in_grid), .o_row(w_row), .o_col(w_col)
  );

  assign w_slot = bus.pix_en & w_in_grid;
  assign w_ready = ~w_slot & ~reset;
  assign w_accept = bus.req_valid & w_ready;

  assign bus.req_ready = w_ready;
  assign bus.ram_en = r_ram_en;
  assign bus.ram_we = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.cell_valid = r_cell_valid;
  assign bus.cell_data = r_cell_data;
  assign bus.cell_row = r_cell_row;
  assign bus.cell_col = r_cell_col;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

  // issue one RAM op per clk, tag reads, and steer returned words by tag two clks later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_addr <= '0;
      r_ram_wdata <= '0;
      r_tag0 <= TAG_NONE;
      r_tag1 <= TAG_NONE;
      r_pos1 <= '0;
      r_cell_valid <= 1'b0;
      r_cell_data <= '0;
      r_cell_row <= '0;
      r_cell_col <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_ram_en <= w_slot | w_accept;
      r_ram_we <= w_accept & bus.req_we;
      r_ram_addr <= w_slot ? {w_row, w_col} : w_accept ? bus.req_addr : r_ram_addr;
      r_ram_wdata <= w_accept ? bus.req_wdata : r_ram_wdata;
      r_tag0 <= w_slot ? TAG_DISP : (w_accept & ~bus.req_we) ? TAG_GAME : TAG_NONE;
      r_tag1 <= r_tag0;
      r_pos1 <= r_ram_addr;
      r_cell_valid <= r_tag1 == TAG_DISP;
      r_rsp_valid <= r_tag1 == TAG_GAME;
      if (r_tag1 == TAG_DISP) begin
        r_cell_data <= bus.ram_rdata;
        {r_cell_row, r_cell_col} <= r_pos1;
      end
      if (r_tag1 == TAG_GAME) r_rsp_rdata <= bus.ram_rdata;
    end
  end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: directed checks of display/game arbitration against a write-first RAM model
module tb_board_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mem [64];

  board_ram_arbiter_if bus();
  board_ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // write-first RAM model, read data one clk after ram_en
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 4'(i) ^ 4'h5;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= bus.ram_wdata;
      end else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pix_en = 1'b0;
    bus.hCount = '0;
    bus.vCount = '0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    bus.pix_en = 1'b1; bus.hCount = 10'd161; bus.vCount = 10'd51;
    tick();
    n_cmp++;
    if ({bus.ram_en, bus.ram_we, bus.cell_valid, bus.rsp_valid} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus.ram_en, bus.ram_we, bus.cell_valid, bus.rsp_valid});
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.cell_data, bus.cell_row, bus.cell_col, bus.rsp_rdata} !== 24'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus.ram_addr, bus.ram_wdata, bus.cell_data, bus.cell_row, bus.cell_col, bus.rsp_rdata});
    end
    idle();
  endtask

  task automatic test_first_cell();
    reset = 1'b0;
    bus.pix_en = 1'b1; bus.hCount = 10'd161; bus.vCount = 10'd51;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready: got %b want 0", bus.req_ready); end
    tick();
    bus.pix_en = 1'b0;
    n_cmp++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 6'd0}) begin
      n_bad++; $display("FAIL first_ram: got en/we/addr %b/%b/%0d want 1/0/0", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    tick();
    n_cmp++;
    if (bus.cell_valid !== 1'b0) begin n_bad++; $display("FAIL first_early: got cell_valid %b want 0", bus.cell_valid); end
    tick();
    n_cmp++;
    if ({bus.cell_valid, bus.rsp_valid, bus.cell_row, bus.cell_col, bus.cell_data} !== {2'b10, 3'd0, 3'd0, 4'h5}) begin
      n_bad++; $display("FAIL first_cell: got v/r/row/col/data %b/%b/%0d/%0d/%h want 1/0/0/0/5",
        bus.cell_valid, bus.rsp_valid, bus.cell_row, bus.cell_col, bus.cell_data);
    end
  endtask

  task automatic test_grid_edges();
    int th[7] = '{735, 160, 736, 300, 300, 232, 233};
    int tv[7] = '{497, 100, 100, 50, 498, 106, 107};
    logic te[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int ta[7] = '{63, 63, 63, 63, 63, 0, 9};
    for (int e = 0; e < 7; e++) begin
      bus.pix_en = 1'b1; bus.hCount = 10'(th[e]); bus.vCount = 10'(tv[e]);
      #1;
      n_cmp++;
      if (bus.req_ready !== !te[e]) begin n_bad++; $display("FAIL edge_ready[%0d]: got %b want %b", e, bus.req_ready, !te[e]); end
      tick();
      bus.pix_en = 1'b0;
      n_cmp++;
      if ({bus.ram_en, bus.ram_addr} !== {te[e], 6'(ta[e])}) begin
        n_bad++; $display("FAIL edge_ram[%0d]: got en/addr %b/%0d want %b/%0d", e, bus.ram_en, bus.ram_addr, te[e], ta[e]);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.cell_valid !== te[e]) begin n_bad++; $display("FAIL edge_cv[%0d]: got %b want %b", e, bus.cell_valid, te[e]); end
      if (te[e]) begin
        n_cmp++;
        if ({bus.cell_row, bus.cell_col, bus.cell_data} !== {6'(ta[e]), 4'(ta[e]) ^ 4'h5}) begin
          n_bad++; $display("FAIL edge_cell[%0d]: got rc/data %0d/%h want %0d/%h", e,
            {bus.cell_row, bus.cell_col}, bus.cell_data, ta[e], 4'(ta[e]) ^ 4'h5);
        end
      end
    end
  endtask

  task automatic test_contention();
    bus.pix_en = 1'b1; bus.hCount = 10'd300; bus.vCount = 10'd200;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 6'd12;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL cont_ready0: got %b want 0", bus.req_ready); end
    tick();
    bus.pix_en = 1'b0;
    n_cmp++;
    if ({bus.ram_en, bus.ram_addr} !== {1'b1, 6'd17}) begin n_bad++; $display("FAIL cont_disp: got en/addr %b/%0d want 1/17", bus.ram_en, bus.ram_addr); end
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL cont_ready1: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 6'd12}) begin
      n_bad++; $display("FAIL cont_game: got en/we/addr %b/%b/%0d want 1/0/12", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    tick();
    n_cmp++;
    if ({bus.cell_valid, bus.rsp_valid, bus.cell_row, bus.cell_col, bus.cell_data} !== {2'b10, 3'd2, 3'd1, 4'h4}) begin
      n_bad++; $display("FAIL cont_cell: got v/r/row/col/data %b/%b/%0d/%0d/%h want 1/0/2/1/4",
        bus.cell_valid, bus.rsp_valid, bus.cell_row, bus.cell_col, bus.cell_data);
    end
    tick();
    n_cmp++;
    if ({bus.cell_valid, bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 4'h9}) begin
      n_bad++; $display("FAIL cont_rsp: got cv/rv/data %b/%b/%h want 0/1/9", bus.cell_valid, bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_write_read();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'd5; bus.req_wdata = 4'hA;
    tick();
    n_cmp++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {2'b11, 6'd5, 4'hA}) begin
      n_bad++; $display("FAIL wr_ram: got en/we/addr/wd %b/%b/%0d/%h want 1/1/5/a", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.req_we = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 6'd5}) begin
      n_bad++; $display("FAIL rd_ram: got en/we/addr %b/%b/%0d want 1/0/5", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.cell_valid} !== 2'b00) begin n_bad++; $display("FAIL wr_norsp: got rv/cv %b/%b want 0/0", bus.rsp_valid, bus.cell_valid); end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.cell_valid, bus.rsp_rdata} !== {2'b10, 4'hA}) begin
      n_bad++; $display("FAIL rd_rsp: got rv/cv/data %b/%b/%h want 1/0/a", bus.rsp_valid, bus.cell_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_interleave();
    localparam int L = 120;
    int kind[L];
    int ea[L];
    int g = 0;
    for (int i = 0; i < L + 3; i++) begin
      if (i >= 3) begin
        n_cmp++;
        if ({bus.cell_valid, bus.rsp_valid} !== {kind[i-3] == 1, kind[i-3] == 2}) begin
          n_bad++; $display("FAIL il_route[%0d]: got cv/rv %b/%b want kind %0d", i - 3, bus.cell_valid, bus.rsp_valid, kind[i-3]);
        end
        n_cmp++;
        if (kind[i-3] == 1 && {bus.cell_row, bus.cell_col, bus.cell_data} !== {6'(ea[i-3]), mem[ea[i-3]]}) begin
          n_bad++; $display("FAIL il_cell[%0d]: got rc/data %0d/%h want %0d/%h", i - 3, {bus.cell_row, bus.cell_col}, bus.cell_data, ea[i-3], mem[ea[i-3]]);
        end else if (kind[i-3] == 2 && bus.rsp_rdata !== mem[ea[i-3]]) begin
          n_bad++; $display("FAIL il_rsp[%0d]: got %h want %h", i - 3, bus.rsp_rdata, mem[ea[i-3]]);
        end
      end
      if (i < L) begin
        int h = 161 + (i / 4) * 20;
        logic pe = (i % 4) == 0;
        logic slot = pe && h > 160 && h < 736;
        bus.pix_en = pe; bus.hCount = 10'(h); bus.vCount = 10'd219;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 6'(g * 7);
        kind[i] = slot ? 1 : 2;
        ea[i] = slot ? 3 * 8 + (h - 161) / 72 : (g * 7) % 64;
        if (!slot) g++;
        #1;
        n_cmp++;
        if (bus.req_ready !== !slot) begin n_bad++; $display("FAIL il_ready[%0d]: got %b want %b", i, bus.req_ready, !slot); end
      end else idle();
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 6'd3;
    tick();
    n_cmp++;
    if ({bus.ram_en, bus.ram_addr} !== {1'b1, 6'd3}) begin n_bad++; $display("FAIL rm_issue: got en/addr %b/%0d want 1/3", bus.ram_en, bus.ram_addr); end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.req_ready, bus.ram_en, bus.ram_we, bus.cell_valid, bus.rsp_valid} !== 5'b0) begin
      n_bad++; $display("FAIL rm_flags: got %b want 00000", {bus.req_ready, bus.ram_en, bus.ram_we, bus.cell_valid, bus.rsp_valid});
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.cell_data, bus.cell_row, bus.cell_col, bus.rsp_rdata} !== 24'h0) begin
      n_bad++; $display("FAIL rm_data: got %h want 0", {bus.ram_addr, bus.ram_wdata, bus.cell_data, bus.cell_row, bus.cell_col, bus.rsp_rdata});
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale3: got rsp_valid %b want 0", bus.rsp_valid); end
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 6'd20;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.ram_en, bus.ram_addr, bus.rsp_valid} !== {1'b1, 6'd20, 1'b0}) begin
      n_bad++; $display("FAIL rm_first: got en/addr/rv %b/%0d/%b want 1/20/0", bus.ram_en, bus.ram_addr, bus.rsp_valid);
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale5: got rsp_valid %b want 0", bus.rsp_valid); end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 4'h1}) begin
      n_bad++; $display("FAIL rm_rsp: got rv/data %b/%h want 1/1", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  initial begin
    idle();
    tick();
    tick();
    preload = 1'b0;
    test_reset();
    test_first_cell();
    test_grid_edges();
    test_contention();
    test_write_read();
    test_interleave();
    test_reset_mid();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
